mdio_host_responder: RTL and testbench
======================================

# mdio_host_responder

Target-side model of the 10G MAC host/management interface. Accepts `host_*` configuration and MIIM requests in the 50 MHz `host_clk` domain, and holds the receiver, transmitter and management configuration words. For MIIM requests it serialises IEEE 802.3 clause-45 MDIO frames on MDC/MDIO toward the PHY. It sits between the host-side management driver and the PHY pins; it is used as the MAC-side responder in simulation and in MAC-less builds.

## Interface

**Parameters**
- `PREAMBLE_LEN`, default 32: number of preamble `1` bits per frame; legal range 0..32.

**Ports**
- `host_clk` in 1: 50 MHz clock.
- `host_reset_n` in 1: reset, asynchronous, active-low.
- `host_opcode` in 2: config access: bit1=1 read, bit1=0 write. MIIM: 00 address, 01 write, 11 read, 10 read-post-increment.
- `host_addr` in 10: config register address. MIIM: [9:5] PRTAD, [4:0] DEVAD.
- `host_wr_data` in 32: config write data. MIIM address/data uses [15:0].
- `host_rd_data` out 32: config or MIIM read data.
- `host_miim_sel` in 1: 1 = MIIM access, 0 = config access.
- `host_req` in 1: MIIM start strobe.
- `host_miim_rdy` out 1: MIIM engine idle.
- `cfg_rx` out 32: config word at 0x240.
- `cfg_tx` out 32: config word at 0x280.
- `cfg_mgmt` out 32: config word at 0x340. [4:0] = clock divide, [5] = MDIO enable.
- `mdc` out 1: MDIO clock.
- `mdio_o` out 1: MDIO output data.
- `mdio_t` out 1: MDIO tristate control; 1 = high-Z.
- `mdio_i` in 1: MDIO input data.

## Operation

**Reset values**
- `host_rd_data` = 0, `cfg_rx`/`cfg_tx`/`cfg_mgmt` = 0, `host_miim_rdy` = 1, `mdc` = 0, `mdio_o` = 1, `mdio_t` = 1.

**Config access** (`host_miim_sel`=0)
- `host_req` is ignored.
- Write: every cycle with `host_opcode[1]`=0, the word at `host_addr` is loaded from `host_wr_data`. Holding the write for several cycles is idempotent. Writes to unmapped addresses are dropped.
- Read: `host_opcode[1]`=1 → `host_rd_data` = selected word on the next cycle; unmapped addresses return 0.
- Config access is legal while an MIIM frame is in flight. A new clock divide takes effect only at the next accepted request.

**MIIM accept**
- A request is accepted when all of these hold in one cycle: IDLE, `host_req`=1, `host_miim_sel`=1, `cfg_mgmt[5]`=1.
- On accept, latch opcode, PRTAD, DEVAD, `host_wr_data[15:0]`, and D = max(`cfg_mgmt[4:0]`, 1).
- Requests while busy, or with MDIO disabled, are ignored; `host_miim_rdy` stays in its current state.

**Frame**
- Bit order: PREAMBLE_LEN ones, ST=00, OP[1:0], PRTAD[4:0] MSB first, DEVAD[4:0] MSB first, TA, DATA[15:0] MSB first.
- TA/DATA for opcode 00/01: TA=10, then the latched data is driven.
- TA/DATA for opcode 11/10: `mdio_t`=1 from the first TA bit through the end of the frame; DATA is sampled from `mdio_i`.

**FSM**
- IDLE → PRE (skipped if PREAMBLE_LEN=0) → HDR (14 bits) → TA (2 bits) → DATA (16 bits) → DONE → IDLE.
- A 6-bit bit counter runs within each state.
- DONE lasts one cycle. For read opcodes, `host_rd_data` = {16'h0, sampled}; it is unchanged for 00/01. Then `host_miim_rdy` = 1, `mdc` = 0, `mdio_t` = 1, `mdio_o` = 1.

## Timing

- Bit period = 2·(D+1) `host_clk`. `mdc` is low for the first D+1 cycles and high for the last D+1 cycles.
- `mdio_o`/`mdio_t` change only at bit start, i.e. on the `mdc` falling edge or at frame start.
- `mdio_i` is sampled in the cycle `mdc` rises.
- For a request sampled at cycle 0:
  - cycle 1: `host_miim_rdy`=0, first bit driven.
  - `host_miim_rdy`=1 at cycle 1 + (PREAMBLE_LEN+32)·2·(D+1).
  - Example: D=1, PREAMBLE_LEN=32 → ready at cycle 257.
- Config read latency: 1 cycle. Config write: visible on `cfg_*` the next cycle.
- An asynchronous reset mid-frame immediately returns the block to IDLE with reset values on all outputs. The PHY sees an aborted frame; no `host_rd_data` update occurs.
- A `host_req` in the same cycle as DONE is ignored. Accept requires IDLE, and `host_miim_rdy`=1 is visible one cycle after DONE.

## Structure

- Shared package `mdio_host_pkg`:
  - address constants `CFG_RX_ADDR`=10'h240, `CFG_TX_ADDR`=10'h280, `CFG_MGMT_ADDR`=10'h340;
  - MIIM opcode constants;
  - FSM state encoding.
- Sub-module `mdc_strobe_gen`: divide counter producing `mdc`, a `rise` strobe and a `fall` strobe. It is enabled only while busy, D is latched at accept, and it is held low while idle.
- Top level: config register file, FSM, frame shift register and read-data capture.

## Test plan

- **Reset/idle:** release reset → `host_miim_rdy`=1, `mdio_t`=1, `mdc`=0, all `cfg_*`=0. Then read 0x340 → `host_rd_data`=0.
- **Config write/read:** write 0x240 ← 0x3C000000 and 0x340 ← 0x00000021, then read both back → same values; read 0x100 → 0.
- **MIIM write:** D=1, opcode 01, addr 0x0A3, data 0xBEEF.
  - Captured on `mdc` rise: 32 ones, then 00 01 00101 00011 10 1011111011101111.
  - `mdio_t`=0 throughout; `host_miim_rdy` low for exactly 256 cycles.
- **MIIM read:** opcode 11, PHY model drives 0x1234 → `mdio_t`=1 from TA onward, `host_rd_data`=0x00001234 when `host_miim_rdy` rises.
  - With no PHY (`mdio_i`=1) → 0x0000FFFF.
- **Ignored requests:**
  - `host_req` with `cfg_mgmt[5]`=0 → no `mdc` toggling.
  - Second `host_req` mid-frame → no effect.
  - Writing 0x340 ← 0x23 mid-frame → current frame keeps D=1; next frame uses D=3 (8-cycle bit period).
- **Reset mid-frame:** assert `host_reset_n` low at bit 40 → outputs return to reset values asynchronously; the next request produces a complete, correct frame.

Source files
------------

// File: rtl/mdio_host_pkg.sv
// Shared constants and types for the MDIO host responder: config map, MIIM opcodes, FSM states.
package mdio_host_pkg;

    localparam logic [9:0] CFG_RX_ADDR   = 10'h240;
    localparam logic [9:0] CFG_TX_ADDR   = 10'h280;
    localparam logic [9:0] CFG_MGMT_ADDR = 10'h340;

    localparam logic [1:0] MIIM_OP_ADDR     = 2'b00;
    localparam logic [1:0] MIIM_OP_WRITE    = 2'b01;
    localparam logic [1:0] MIIM_OP_READ_INC = 2'b10;
    localparam logic [1:0] MIIM_OP_READ     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } miim_state_e;

    // Both read flavours release the bus for TA and DATA.
    function automatic logic is_read_op(input logic [1:0] op);
        return op[1];
    endfunction

    // A divide of zero would collapse the MDC low/high phases, so it is treated as one.
    function automatic logic [4:0] clamp_div(input logic [4:0] div);
        return (div == 5'd0) ? 5'd1 : div;
    endfunction

endpackage

// File: rtl/mdc_strobe_gen.sv
// MDC divider: each bit lasts 2*(D+1) host_clk cycles, MDC low for the first half.
// D is captured at frame start so a divide change mid-frame cannot distort the frame.
module mdc_strobe_gen
    import mdio_host_pkg::*;
(
    input  logic       host_clk,
    input  logic       host_reset_n,
    input  logic       start,
    input  logic       en,
    input  logic [4:0] div_in,
    output logic       mdc,
    output logic       rise,
    output logic       fall,
    output logic       pre_fall
);
    logic [4:0] div_q;
    logic [5:0] cnt;
    logic [5:0] half_len;
    logic [5:0] bit_last;

    assign half_len = {1'b0, div_q} + 6'd1;
    assign bit_last = {div_q, 1'b1};

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so ordering between blocks never matters.
    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            div_q <= 5'd1;
            cnt   <= '0;
        end else if (start) begin
            div_q <= clamp_div(div_in);
            cnt   <= '0;
        end else if (!en || cnt == bit_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 6'd1;
        end
    end

    assign mdc      = en && (cnt >= half_len);
    assign rise     = en && (cnt == half_len);
    assign fall     = en && (cnt == bit_last);
    assign pre_fall = en && (cnt == bit_last - 6'd1);

endmodule

// File: rtl/mdio_host_responder.sv
// Host management responder: config register file plus a clause-45 MIIM frame engine on MDC/MDIO.
module mdio_host_responder
    import mdio_host_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        host_clk,
    input  logic        host_reset_n,
    input  logic [1:0]  host_opcode,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wr_data,
    output logic [31:0] host_rd_data,
    input  logic        host_miim_sel,
    input  logic        host_req,
    output logic        host_miim_rdy,
    output logic [31:0] cfg_rx,
    output logic [31:0] cfg_tx,
    output logic [31:0] cfg_mgmt,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

    miim_state_e state, state_nxt;
    logic [5:0]  bit_cnt;
    logic [31:0] frame_sr;
    logic [1:0]  op_q;
    logic [15:0] rd_shift;
    logic [31:0] cfg_word;
    logic        cfg_write, cfg_read, accept, busy;
    logic        mdc_rise, mdc_fall, mdc_pre_fall;

    assign cfg_write     = !host_miim_sel && !host_opcode[1];
    assign cfg_read      = !host_miim_sel &&  host_opcode[1];
    assign accept        = (state == ST_IDLE) && host_req && host_miim_sel && cfg_mgmt[5];
    assign busy          = (state != ST_IDLE);
    assign host_miim_rdy = (state == ST_IDLE);

    mdc_strobe_gen u_mdc (
        .host_clk     (host_clk),
        .host_reset_n (host_reset_n),
        .start        (accept),
        .en           (busy),
        .div_in       (cfg_mgmt[4:0]),
        .mdc          (mdc),
        .rise         (mdc_rise),
        .fall         (mdc_fall),
        .pre_fall     (mdc_pre_fall)
    );

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            cfg_rx   <= '0;
            cfg_tx   <= '0;
            cfg_mgmt <= '0;
        end else if (cfg_write) begin
            case (host_addr)
                CFG_RX_ADDR:   cfg_rx   <= host_wr_data;
                CFG_TX_ADDR:   cfg_tx   <= host_wr_data;
                CFG_MGMT_ADDR: cfg_mgmt <= host_wr_data;
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default before the case, otherwise unlisted paths infer latches.
    always_comb begin
        cfg_word = '0;
        case (host_addr)
            CFG_RX_ADDR:   cfg_word = cfg_rx;
            CFG_TX_ADDR:   cfg_word = cfg_tx;
            CFG_MGMT_ADDR: cfg_word = cfg_mgmt;
            default: ;
        endcase
    end

    // A completing MIIM read takes precedence over a coincident config read.
    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            host_rd_data <= '0;
        end else if (state == ST_DONE && is_read_op(op_q)) begin
            host_rd_data <= {16'h0, rd_shift};
        end else if (cfg_read) begin
            host_rd_data <= cfg_word;
        end
    end

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) state <= ST_IDLE;
        else               state <= state_nxt;
    end

    // DONE occupies the final cycle of the last bit so ready rises right after the frame ends.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                         state_nxt = (PREAMBLE_LEN == 0) ? ST_HDR : ST_PRE;
            ST_PRE:  if (mdc_fall && bit_cnt == PRE_LAST) state_nxt = ST_HDR;
            ST_HDR:  if (mdc_fall && bit_cnt == 6'd13)    state_nxt = ST_TA;
            ST_TA:   if (mdc_fall && bit_cnt == 6'd1)     state_nxt = ST_DATA;
            ST_DATA: if (mdc_pre_fall && bit_cnt == 6'd15) state_nxt = ST_DONE;
            ST_DONE:                                      state_nxt = ST_IDLE;
            default:                                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            op_q     <= '0;
            frame_sr <= '0;
            bit_cnt  <= '0;
            rd_shift <= '0;
        end else begin
            if (accept) begin
                op_q     <= host_opcode;
                frame_sr <= {2'b00, host_opcode, host_addr[9:5], host_addr[4:0], 2'b10, host_wr_data[15:0]};
                bit_cnt  <= '0;
            end else if (mdc_fall) begin
                bit_cnt <= (state_nxt != state) ? 6'd0 : bit_cnt + 6'd1;
                if (state inside {ST_HDR, ST_TA, ST_DATA}) frame_sr <= {frame_sr[30:0], 1'b0};
            end
            if (state == ST_DATA && mdc_rise) rd_shift <= {rd_shift[14:0], mdio_i};
        end
    end

    // Pins are pure functions of registered state, so they only move at bit boundaries.
    always_comb begin
        mdio_o = 1'b1;
        mdio_t = 1'b1;
        case (state)
            ST_PRE: mdio_t = 1'b0;
            ST_HDR: begin
                mdio_o = frame_sr[31];
                mdio_t = 1'b0;
            end
            ST_TA, ST_DATA, ST_DONE: begin
                mdio_t = is_read_op(op_q);
                mdio_o = is_read_op(op_q) ? 1'b1 : frame_sr[31];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdio_host_responder.sv
// Self-checking bench: config table, MIIM frames against a field-level frame model, corner sequences.
module tb_mdio_host_responder;
    import mdio_host_pkg::*;

    localparam int P = 32;

    logic        host_clk      = 1'b0;
    logic        host_reset_n  = 1'b0;
    logic [1:0]  host_opcode   = 2'b00;
    logic [9:0]  host_addr     = '0;
    logic [31:0] host_wr_data  = '0;
    logic        host_miim_sel = 1'b1;
    logic        host_req      = 1'b0;
    logic        mdio_i        = 1'b1;
    logic [31:0] host_rd_data, cfg_rx, cfg_tx, cfg_mgmt;
    logic        host_miim_rdy, mdc, mdio_o, mdio_t;

    mdio_host_responder #(.PREAMBLE_LEN(P)) dut (
        .host_clk      (host_clk),
        .host_reset_n  (host_reset_n),
        .host_opcode   (host_opcode),
        .host_addr     (host_addr),
        .host_wr_data  (host_wr_data),
        .host_rd_data  (host_rd_data),
        .host_miim_sel (host_miim_sel),
        .host_req      (host_req),
        .host_miim_rdy (host_miim_rdy),
        .cfg_rx        (cfg_rx),
        .cfg_tx        (cfg_tx),
        .cfg_mgmt      (cfg_mgmt),
        .mdc           (mdc),
        .mdio_o        (mdio_o),
        .mdio_t        (mdio_t),
        .mdio_i        (mdio_i)
    );

    always #10 host_clk = ~host_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pin monitor and PHY model, both keyed on MDC edges only.
    logic        cap_o[$];
    logic        cap_t[$];
    int          falls     = 0;
    int          fall_base = 0;
    logic        phy_on    = 1'b0;
    logic [15:0] phy_word  = '0;

    always @(posedge mdc) begin
        cap_o.push_back(mdio_o);
        cap_t.push_back(mdio_t);
    end

    always @(negedge mdc) begin
        int idx;
        falls++;
        idx = falls - fall_base;
        if (phy_on && idx >= P + 16 && idx <= P + 31) mdio_i = phy_word[4'(P + 31 - idx)];
        else                                          mdio_i = 1'b1;
    end

    // Reference model state.
    logic [31:0] m_rx = '0, m_tx = '0, m_mgmt = '0, m_rd = '0;
    logic        exp_o[$];
    logic        exp_t[$];

    function automatic logic [31:0] model_word(input logic [9:0] a);
        case (a)
            CFG_RX_ADDR:   return m_rx;
            CFG_TX_ADDR:   return m_tx;
            CFG_MGMT_ADDR: return m_mgmt;
            default:       return 32'h0;
        endcase
    endfunction

    task automatic build_expected(input logic [1:0] op, input logic [9:0] addr, input logic [15:0] data);
        logic [13:0] hdr;
        hdr = {2'b00, op, addr[9:5], addr[4:0]};
        exp_o.delete();
        exp_t.delete();
        for (int i = 0; i < P; i++) begin exp_o.push_back(1'b1); exp_t.push_back(1'b0); end
        for (int i = 13; i >= 0; i--) begin exp_o.push_back(hdr[i]); exp_t.push_back(1'b0); end
        if (op[1]) begin
            for (int i = 0; i < 18; i++) begin exp_o.push_back(1'b1); exp_t.push_back(1'b1); end
        end else begin
            exp_o.push_back(1'b1); exp_t.push_back(1'b0);
            exp_o.push_back(1'b0); exp_t.push_back(1'b0);
            for (int i = 15; i >= 0; i--) begin exp_o.push_back(data[i]); exp_t.push_back(1'b0); end
        end
    endtask

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic set_idle();
        host_miim_sel = 1'b1;
        host_req      = 1'b0;
        host_opcode   = 2'b00;
    endtask

    task automatic check_cfg_ports(input string tag);
        check({tag, "_rx"},   cfg_rx,   m_rx);
        check({tag, "_tx"},   cfg_tx,   m_tx);
        check({tag, "_mgmt"}, cfg_mgmt, m_mgmt);
    endtask

    task automatic cfg_write(input logic [9:0] a, input logic [31:0] d);
        host_miim_sel = 1'b0;
        host_opcode   = 2'b00;
        host_addr     = a;
        host_wr_data  = d;
        tick();
        tick();
        set_idle();
        case (a)
            CFG_RX_ADDR:   m_rx   = d;
            CFG_TX_ADDR:   m_tx   = d;
            CFG_MGMT_ADDR: m_mgmt = d;
            default: ;
        endcase
        check_cfg_ports("cfg_wr");
    endtask

    task automatic cfg_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
        host_miim_sel = 1'b0;
        host_opcode   = 2'b10;
        host_addr     = a;
        tick();
        check(tag, host_rd_data, exp);
        m_rd = exp;
        set_idle();
    endtask

    task automatic compare_frame(input string tag, input int base);
        int errs = 0;
        check({tag, "_nbits"}, 32'(cap_o.size() - base), 32'(exp_o.size()));
        for (int i = 0; i < exp_o.size() && base + i < cap_o.size(); i++) begin
            if (cap_t[base + i] !== exp_t[i] || (!exp_t[i] && cap_o[base + i] !== exp_o[i])) begin
                if (errs == 0)
                    $display("%s bit %0d: o=%b t=%b want o=%b t=%b", tag, i,
                             cap_o[base + i], cap_t[base + i], exp_o[i], exp_t[i]);
                errs++;
            end
        end
        check({tag, "_bits"}, 32'(errs), 32'd0);
    endtask

    // poke_kind 1: second request mid-frame; 2: divide rewritten mid-frame.
    task automatic miim_run(input logic [1:0] op, input logic [9:0] addr, input logic [15:0] data,
                            input logic phy_en, input logic [15:0] word,
                            input int poke_at, input int poke_kind, input string tag);
        int d, n, base;
        d = (m_mgmt[4:0] == 5'd0) ? 1 : int'(m_mgmt[4:0]);
        build_expected(op, addr, data);
        phy_on        = phy_en;
        phy_word      = word;
        fall_base     = falls;
        base          = cap_o.size();
        host_miim_sel = 1'b1;
        host_opcode   = op;
        host_addr     = addr;
        host_wr_data  = {16'hA5A5, data};
        host_req      = 1'b1;
        tick();
        set_idle();
        n = 0;
        while (!host_miim_rdy && n < 5000) begin
            n++;
            if (n == poke_at && poke_kind == 1) begin
                host_opcode = ~op;
                host_addr   = ~addr;
                host_req    = 1'b1;
            end else if (n == poke_at && poke_kind == 2) begin
                host_miim_sel = 1'b0;
                host_opcode   = 2'b00;
                host_addr     = CFG_MGMT_ADDR;
                host_wr_data  = 32'h23;
                m_mgmt        = 32'h23;
            end
            tick();
            set_idle();
        end
        check({tag, "_busy"}, 32'(n), 32'((P + 32) * 2 * (d + 1)));
        compare_frame(tag, base);
        if (op[1]) m_rd = {16'h0, phy_en ? word : 16'hFFFF};
        check({tag, "_rd"}, host_rd_data, m_rd);
        check({tag, "_pins"}, {29'h0, mdc, mdio_t, mdio_o}, 32'h3);
    endtask

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } cfg_vec_t;

    initial begin
        cfg_vec_t    vecs[10];
        logic [9:0]  a;
        logic [31:0] d;
        int          base, k, lows;

        vecs[0] = '{1'b0, CFG_MGMT_ADDR, 32'h0,          32'h0};
        vecs[1] = '{1'b1, CFG_RX_ADDR,   32'h3C00_0000,  32'h0};
        vecs[2] = '{1'b1, CFG_MGMT_ADDR, 32'h0000_0021,  32'h0};
        vecs[3] = '{1'b1, 10'h100,       32'hFFFF_FFFF,  32'h0};
        vecs[4] = '{1'b1, CFG_TX_ADDR,   32'hA5A5_0F0F,  32'h0};
        vecs[5] = '{1'b0, CFG_RX_ADDR,   32'h0,          32'h3C00_0000};
        vecs[6] = '{1'b0, CFG_MGMT_ADDR, 32'h0,          32'h0000_0021};
        vecs[7] = '{1'b0, 10'h100,       32'h0,          32'h0};
        vecs[8] = '{1'b0, CFG_TX_ADDR,   32'h0,          32'hA5A5_0F0F};
        vecs[9] = '{1'b0, 10'h3FF,       32'h0,          32'h0};

        repeat (3) tick();
        check("rst_rdy",  {31'h0, host_miim_rdy}, 32'h1);
        check("rst_pins", {29'h0, mdc, mdio_t, mdio_o}, 32'h3);
        check("rst_rd",   host_rd_data, 32'h0);
        check_cfg_ports("rst");
        host_reset_n = 1'b1;
        tick();
        check("idle_rdy", {31'h0, host_miim_rdy}, 32'h1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].data);
            else            cfg_read(vecs[i].addr, vecs[i].exp, "tbl_rd");
        end

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       a = CFG_RX_ADDR;
                1:       a = CFG_TX_ADDR;
                2:       a = CFG_MGMT_ADDR;
                default: a = 10'($urandom_range(0, 1023));
            endcase
            d = $urandom;
            if ($urandom_range(0, 1) == 1) cfg_write(a, d);
            else                          cfg_read(a, model_word(a), "rnd_rd");
        end

        cfg_write(CFG_MGMT_ADDR, 32'h21);
        miim_run(MIIM_OP_WRITE, 10'h0A3, 16'hBEEF, 1'b0, 16'h0,    0, 0, "wr");
        miim_run(MIIM_OP_READ,  10'h0A3, 16'h0,    1'b1, 16'h1234, 0, 0, "rd_phy");
        miim_run(MIIM_OP_READ,  10'h0A3, 16'h0,    1'b0, 16'h0,    0, 0, "rd_nophy");
        miim_run(MIIM_OP_WRITE, 10'h2C7, 16'h1357, 1'b0, 16'h0,  100, 1, "second_req");
        miim_run(MIIM_OP_ADDR,  10'h041, 16'h8001, 1'b0, 16'h0,   60, 2, "div_change");
        check_cfg_ports("div_change");
        miim_run(MIIM_OP_READ_INC, 10'h3E1, 16'h0, 1'b1, 16'hF00D, 0, 0, "div3");

        cfg_write(CFG_MGMT_ADDR, 32'h03);
        base          = cap_o.size();
        lows          = 0;
        host_miim_sel = 1'b1;
        host_opcode   = MIIM_OP_WRITE;
        host_req      = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!host_miim_rdy) lows++;
        end
        set_idle();
        check("dis_mdc_edges", 32'(cap_o.size() - base), 32'h0);
        check("dis_rdy_low",   32'(lows), 32'h0);

        for (int i = 0; i < 4; i++) begin
            cfg_write(CFG_MGMT_ADDR, 32'h20 | 32'($urandom_range(0, 2)));
            miim_run(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), 16'($urandom),
                     1'($urandom_range(0, 1)), 16'($urandom), 0, 0, "rnd_miim");
        end

        cfg_write(CFG_MGMT_ADDR, 32'h21);
        base          = cap_o.size();
        fall_base     = falls;
        phy_on        = 1'b1;
        phy_word      = 16'h5555;
        host_miim_sel = 1'b1;
        host_opcode   = MIIM_OP_READ;
        host_addr     = 10'h155;
        host_req      = 1'b1;
        tick();
        set_idle();
        k = 0;
        while (cap_o.size() - base < 40 && k < 1000) begin
            k++;
            tick();
        end
        check("rst_mid_reach", {31'h0, (cap_o.size() - base) >= 40}, 32'h1);
        #3 host_reset_n = 1'b0;
        #1;
        check("rst_mid_rdy",  {31'h0, host_miim_rdy}, 32'h1);
        check("rst_mid_pins", {29'h0, mdc, mdio_t, mdio_o}, 32'h3);
        check("rst_mid_rd",   host_rd_data, 32'h0);
        m_rx   = '0;
        m_tx   = '0;
        m_mgmt = '0;
        m_rd   = '0;
        check_cfg_ports("rst_mid");
        @(posedge host_clk);
        #5 host_reset_n = 1'b1;
        tick();
        cfg_write(CFG_MGMT_ADDR, 32'h21);
        miim_run(MIIM_OP_READ, 10'h155, 16'h0, 1'b1, 16'hC3A5, 0, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
